// File: rtl/fp16_tpu_pkg.sv
// Shared types and constants for the FP16 systolic tile controller.
// State encoding, the FP16 zero constant and the drain-length helper.
package fp16_tpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } seq_state_t;

    localparam logic [15:0] FP16_ZERO = 16'h0000;

    // Last operand needs SIZE-1 skew hops plus SIZE-1 array hops, then the MAC itself.
    function automatic int drain_cycles(input int size, input int mac_lat);
        return 2 * (size - 1) + mac_lat;
    endfunction

endpackage

// File: rtl/fp16_skew_buffer.sv
// Triangular skew bank: lane i is delayed by i shift-enabled cycles,
// lane 0 is a combinational pass-through. Synchronous clear loads FP16 zero.
module fp16_skew_buffer
    import fp16_tpu_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                shift,
    input  logic [16*SIZE-1:0]  din,
    output logic [16*SIZE-1:0]  dout
);

    assign dout[15:0] = din[15:0];

    for (genvar i = 1; i < SIZE; i++) begin : g_lane
        logic [15:0] pipe [i];

        always_ff @(posedge clk) begin
            if (clear) begin
                for (int k = 0; k < i; k++) pipe[k] <= FP16_ZERO;
            end else if (shift) begin
                pipe[0] <= din[16*i +: 16];
                for (int k = 1; k < i; k++) pipe[k] <= pipe[k-1];
            end
        end

        assign dout[16*i +: 16] = pipe[i-1];
    end

endmodule

// File: rtl/fp16_systolic_tile_sequencer.sv
// Runs one output-stationary tile: clear, skewed operand feed, zero drain, done.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module fp16_systolic_tile_sequencer
    import fp16_tpu_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int K_W     = 16,
    parameter int MAC_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [K_W-1:0]      k_len,
    output logic                busy,
    output logic                done,
    input  logic                vec_valid,
    output logic                vec_ready,
    input  logic [16*SIZE-1:0]  a_vec,
    input  logic [16*SIZE-1:0]  w_vec,
    output logic                arr_enable,
    output logic                arr_acc_clear,
    output logic [16*SIZE-1:0]  arr_a,
    output logic [16*SIZE-1:0]  arr_w,
    output logic [31:0]         perf_busy_cycles,
    output logic [31:0]         perf_stall_cycles
);

    localparam int              DRAIN_CYCLES = drain_cycles(SIZE, MAC_LAT);
    localparam int              DRN_W        = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRN_W-1:0] DRN_LOAD    = DRN_W'(DRAIN_CYCLES - 1);

    seq_state_t        state;
    logic [K_W-1:0]    k_q;
    logic [K_W-1:0]    beat_cnt;
    logic [DRN_W-1:0]  drain_cnt;
    logic              en_q;
    logic              beat;
    logic              shift;
    logic              skew_clear;
    logic [16*SIZE-1:0] src_a;
    logic [16*SIZE-1:0] src_w;

    assign beat       = vec_valid & vec_ready;
    // Stalls gate enable in the same cycle so the array and skew banks freeze together.
    assign arr_enable = en_q | beat;
    assign shift      = beat | (state == DRAIN);
    assign skew_clear = rst | (state == CLEAR);
    assign src_a      = beat ? a_vec : {SIZE{FP16_ZERO}};
    assign src_w      = beat ? w_vec : {SIZE{FP16_ZERO}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            vec_ready     <= 1'b0;
            arr_acc_clear <= 1'b0;
            en_q          <= 1'b0;
            k_q           <= '0;
            beat_cnt      <= '0;
            drain_cnt     <= '0;
        end else begin
            done          <= 1'b0;
            arr_acc_clear <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= CLEAR;
                        k_q           <= k_len;
                        busy          <= 1'b1;
                        arr_acc_clear <= 1'b1;
                        en_q          <= 1'b1;
                    end
                end
                CLEAR: begin
                    beat_cnt <= k_q;
                    if (k_q != '0) begin
                        state     <= FEED;
                        vec_ready <= 1'b1;
                        en_q      <= 1'b0;
                    end else begin
                        state     <= DRAIN;
                        drain_cnt <= DRN_LOAD;
                    end
                end
                FEED: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt - K_W'(1);
                        if (beat_cnt == K_W'(1)) begin
                            state     <= DRAIN;
                            vec_ready <= 1'b0;
                            en_q      <= 1'b1;
                            drain_cnt <= DRN_LOAD;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= DONE;
                        en_q  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DRN_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    vec_ready <= 1'b0;
                    en_q      <= 1'b0;
                end
            endcase
        end
    end

    fp16_skew_buffer #(.SIZE(SIZE)) u_skew_a (
        .clk   (clk),
        .clear (skew_clear),
        .shift (shift),
        .din   (src_a),
        .dout  (arr_a)
    );

    fp16_skew_buffer #(.SIZE(SIZE)) u_skew_w (
        .clk   (clk),
        .clear (skew_clear),
        .shift (shift),
        .din   (src_w),
        .dout  (arr_w)
    );

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] busy_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || (state == IDLE && start)) begin
            busy_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (busy && busy_cnt != 32'hFFFF_FFFF) busy_cnt <= busy_cnt + 32'd1;
            if (vec_ready && !vec_valid && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign perf_busy_cycles  = busy_cnt;
    assign perf_stall_cycles = stall_cnt;
`else
    assign perf_busy_cycles  = 32'd0;
    assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: doc/fp16_systolic_tile_sequencer.md
# fp16_systolic_tile_sequencer

Controller that runs one output-stationary tile computation on the 8x8 FP16 approximate systolic array. It accepts a start command with a reduction length K, clears the PE accumulators, and streams K activation and weight vectors into the array with the diagonal row and column skew the array needs. It then flushes the array with zeros and signals done once every PE holds its final dot product. It sits between the operand buffers/DMA and the array's `enable`/`acc_clear`/`a_in_*`/`w_in_*` pins.

## Interface
Parameters:
- `SIZE`, 8: array dimension, equal to the number of lanes.
- `K_W`, 16: width of `k_len`.
- `MAC_LAT`, 1: PE multiply-accumulate latency, in enabled cycles.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `k_len`  in  K_W  reduction length; captured when `start` is accepted.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when results are final.
- `vec_valid`  in  1  an activation/weight vector pair is present.
- `vec_ready`  out  1  high only in FEED.
- `a_vec`  in  16*SIZE  activations; lane i at bits [16i+15:16i].
- `w_vec`  in  16*SIZE  weights, same lane packing.
- `arr_enable`  out  1  drives the array's `enable`.
- `arr_acc_clear`  out  1  drives the array's `acc_clear`.
- `arr_a`  out  16*SIZE  skewed activations to `a_in_0..7`.
- `arr_w`  out  16*SIZE  skewed weights to `w_in_0..7`.
- `perf_busy_cycles`  out  32  cycles spent with `busy` high.
- `perf_stall_cycles`  out  32  FEED cycles with `vec_valid` low.

Reset value of every output is 0.

## Operation
States and transitions:
- IDLE → CLEAR on `start`.
- CLEAR → FEED if `k_len` != 0; CLEAR → DRAIN if `k_len` == 0.
- FEED → DRAIN after the K-th accepted beat.
- DRAIN → DONE when the drain counter expires.
- DONE → IDLE unconditionally.

Per-state behaviour:
- CLEAR (1 cycle):
  - `arr_acc_clear`=1, `arr_enable`=1.
  - All skew registers load FP16 +0 (16'h0000).
  - The beat counter is loaded.
- FEED:
  - A beat is accepted when `vec_valid`&&`vec_ready`.
  - On a beat: `arr_enable`=1, the skew buffers shift, and the beat counter decrements.
  - On no beat (stall): `arr_enable`=0 and the skew buffers hold, so the whole array freezes coherently.
  - The transition to DRAIN occurs in the cycle the counter reaches 0.
- DRAIN:
  - Lasts DRAIN_CYCLES = 2*(SIZE-1)+MAC_LAT cycles, 15 at the defaults.
  - `arr_enable`=1 throughout.
  - FP16 +0 is injected into every skew-buffer lane.
- DONE: `done`=1 for one cycle and `arr_enable`=0.
- After DONE, the array accumulators hold their results until the next CLEAR, because `arr_enable` stays 0 in IDLE.

Skew:
- Activation lane i is delayed by i enabled cycles.
- Weight lane j is delayed by j enabled cycles.
- Lane 0 passes through combinationally from its source (beat data or the zero injection).

Other rules:
- `start` while `busy` is ignored; no queueing.
- `k_len` is held internally after capture; input changes after capture have no effect.
- Counter widths: the beat counter is K_W bits; the drain counter is clog2(DRAIN_CYCLES+1) bits.

## Timing
- `start` is accepted at cycle 0.
- CLEAR occurs at cycle 1.
- FEED runs from cycle 2 and lasts K + (number of stall cycles).
- `done` asserts at cycle 2+K+S+DRAIN_CYCLES, where S is the stall count.
  - At the defaults with no stalls: cycle 17+K.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- `vec_ready` is registered from state and has no combinational path from `vec_valid`.
- `rst` at any time:
  - Next state is IDLE.
  - Skew buffers, counters and outputs are cleared.
  - `arr_acc_clear` is not pulsed.
  - Any in-flight beat is dropped; no `done` is produced.

## Configuration
- Macro `SEQ_PERF_CNT_EN`.
- Defined: `perf_busy_cycles` and `perf_stall_cycles` are live counters.
  - Both are cleared on `rst` and on accepted `start`.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: no counter flops are built and both ports are tied to 0.
- The ports exist in both builds.

## Structure
- Shared package `fp16_tpu_pkg` holds:
  - the state enum (IDLE, CLEAR, FEED, DRAIN, DONE);
  - the constant `FP16_ZERO` = 16'h0000;
  - the DRAIN_CYCLES function of SIZE and MAC_LAT.
- Sub-module `fp16_skew_buffer`: a triangular shift-register bank with parameter SIZE, a shift-enable input and a synchronous clear. It is instantiated twice, once for activations and once for weights.

## Test plan
- K=1, a_vec all lanes 16'h3C00 (1.0), w_vec all 16'h4000 (2.0), no stalls:
  - `done` at cycle 18;
  - every PE reads ~16'h4000 (2.0) within approximate-MAC tolerance.
- K=8, random vectors, no stalls:
  - `done` at cycle 25;
  - all 64 outputs match the reference matmul within tolerance;
  - `busy` high for cycles 1–25.
- K=4 with `vec_valid` low for 3 cycles mid-stream:
  - `done` at cycle 24;
  - results identical to the no-stall run;
  - `perf_stall_cycles`=3 when `SEQ_PERF_CNT_EN` is defined.
- `k_len`=0:
  - CLEAR then DRAIN;
  - `done` at cycle 17;
  - all accumulators read 16'h0000.
- `start` reasserted during FEED is ignored, and `done` occurs exactly once.
- `rst` mid-DRAIN:
  - next cycle `busy`=0 and `arr_enable`=0;
  - no `done`;
  - a subsequent `start` with K=2 completes normally at cycle 19.
